// File: rtl/key_scan_pkg.sv
// rtl/key_scan_pkg.sv - shared scan states, widths and key-map helpers for the keypad scanner
// Contents:
//   scan_state_t  one-hot column scan states SCAN0..SCAN3
//   T1MS_DEFAULT  last count of one 1 ms column slot at 50 MHz
//   KEY_W         key index width, FRAME_W full-matrix snapshot width
//   col_index     scan state -> column number
//   single_key    map has exactly one bit set
//   key_index     bit position of the (single) set bit
package key_scan_pkg;

  localparam int KEY_W    = 4;
  localparam int FRAME_W  = 16;
  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  localparam logic [15:0] T1MS_DEFAULT = 16'd49999;

  typedef enum logic [3:0] {
    SCAN0 = 4'b0001,
    SCAN1 = 4'b0010,
    SCAN2 = 4'b0100,
    SCAN3 = 4'b1000
  } scan_state_t;

  function automatic logic [1:0] col_index(input scan_state_t s);
    logic [1:0] c;
    case (s)
      SCAN0:   c = 2'd0;
      SCAN1:   c = 2'd1;
      SCAN2:   c = 2'd2;
      SCAN3:   c = 2'd3;
      default: c = 2'd0;
    endcase
    return c;
  endfunction

  // Clearing the lowest set bit leaves zero only for a power of two.
  function automatic logic single_key(input logic [FRAME_W-1:0] map);
    return (map != '0) && ((map & (map - FRAME_W'(1))) == '0);
  endfunction

  function automatic logic [KEY_W-1:0] key_index(input logic [FRAME_W-1:0] map);
    logic [KEY_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < FRAME_W; i++) begin
      if (map[i]) idx = KEY_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - frame-level debouncer and single-key press event generator
// Optional feature: KEY_REPEAT_EN builds the auto-repeat counter.
// Ports:
//   clk          system clock
//   rst          synchronous active-low reset
//   frame_valid  one-cycle strobe, snapshot holds a completed frame
//   snapshot     16-bit pressed map, bit row*4+col
//   key_code     index of the pressed key, held until the next event
//   key_valid    one-cycle press (or repeat) event
//   key_down     stable map has at least one key pressed
module key_debounce
  import key_scan_pkg::*;
#(
  parameter logic [3:0] DEBOUNCE_FRAMES = 4'd5
`ifdef KEY_REPEAT_EN
  ,
  parameter logic [7:0] REPEAT_FRAMES   = 8'd125
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_valid,
  input  logic [FRAME_W-1:0] snapshot,
  output logic [KEY_W-1:0]   key_code,
  output logic               key_valid,
  output logic               key_down
);

  logic [FRAME_W-1:0] prev_snap;
  logic [FRAME_W-1:0] stable_map;
  logic [3:0]         match_cnt;

  logic [3:0]         match_nxt;
  logic [FRAME_W-1:0] stable_nxt;
  logic               press_evt;

  // Only an all-zero -> one-key transition is a press; a multi-key map
  // collapsing to one key is not, so a fresh press needs a release first.
  always_comb begin
    match_nxt  = match_cnt;
    stable_nxt = stable_map;
    if (snapshot == prev_snap) begin
      if (match_cnt < DEBOUNCE_FRAMES) match_nxt = match_cnt + 4'd1;
    end else begin
      match_nxt = 4'd1;
    end
    if (match_nxt == DEBOUNCE_FRAMES) stable_nxt = snapshot;
    press_evt = (stable_map == '0) && single_key(stable_nxt);
  end

`ifdef KEY_REPEAT_EN
  logic [7:0] rep_cnt;
  logic [7:0] rep_nxt;
  logic       rep_armed;
  logic       rep_evt;

  // Repeats only follow a real press event; any stable-map change restarts.
  always_comb begin
    rep_nxt = rep_cnt;
    rep_evt = 1'b0;
    if (stable_nxt != stable_map) begin
      rep_nxt = 8'd0;
    end else if (rep_armed) begin
      if (rep_cnt + 8'd1 == REPEAT_FRAMES) begin
        rep_evt = 1'b1;
        rep_nxt = 8'd0;
      end else begin
        rep_nxt = rep_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rep_cnt   <= 8'd0;
      rep_armed <= 1'b0;
    end else if (frame_valid) begin
      rep_cnt <= rep_nxt;
      if (press_evt) rep_armed <= 1'b1;
      else if (stable_nxt != stable_map) rep_armed <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      prev_snap  <= '0;
      stable_map <= '0;
      match_cnt  <= 4'd0;
      key_code   <= '0;
      key_valid  <= 1'b0;
      key_down   <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (frame_valid) begin
        prev_snap  <= snapshot;
        match_cnt  <= match_nxt;
        stable_map <= stable_nxt;
        key_down   <= |stable_nxt;
        if (press_evt) begin
          key_valid <= 1'b1;
          key_code  <= key_index(stable_nxt);
        end
`ifdef KEY_REPEAT_EN
        else if (rep_evt) begin
          key_valid <= 1'b1;
        end
`endif
      end
    end
  end

endmodule

// File: rtl/key_scan_module.sv
// rtl/key_scan_module.sv - 4x4 matrix keypad scanner with debounced single-key events
// Optional feature: KEY_REPEAT_EN enables auto-repeat every REPEAT_FRAMES frames.
// Ports:
//   clk        system clock
//   rst        synchronous active-low reset
//   Row_Sig    keypad rows, active-low, asynchronous to clk
//   Col_Sig    column drive, exactly one bit low
//   Key_Code   pressed key index row*4+col, held until next event
//   Key_Valid  one-cycle press-event pulse
//   Key_Down   debounced map has at least one key pressed
module key_scan_module
  import key_scan_pkg::*;
#(
  parameter logic [15:0] T1MS            = T1MS_DEFAULT,
  parameter logic [3:0]  DEBOUNCE_FRAMES = 4'd5,
  parameter logic [7:0]  REPEAT_FRAMES   = 8'd125
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       Row_Sig,
  output logic [3:0]       Col_Sig,
  output logic [KEY_W-1:0] Key_Code,
  output logic             Key_Valid,
  output logic             Key_Down
);

  logic [15:0]        time_cnt;
  logic               tick;
  scan_state_t        state;
  logic [3:0]         row_meta;
  logic [3:0]         row_sync;
  logic [FRAME_W-1:0] snapshot;
  logic [FRAME_W-1:0] snap_nxt;
  logic               frame_valid;
  logic [1:0]         col_sel;

  assign tick    = (time_cnt == T1MS);
  assign col_sel = col_index(state);

  always_ff @(posedge clk) begin
    if (!rst) begin
      time_cnt <= 16'd0;
    end else if (tick) begin
      time_cnt <= 16'd0;
    end else begin
      time_cnt <= time_cnt + 16'd1;
    end
  end

  // Column drive is registered alongside the state so it never glitches.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= SCAN0;
      Col_Sig <= ~SCAN0;
    end else if (tick) begin
      case (state)
        SCAN0: begin
          state   <= SCAN1;
          Col_Sig <= ~SCAN1;
        end
        SCAN1: begin
          state   <= SCAN2;
          Col_Sig <= ~SCAN2;
        end
        SCAN2: begin
          state   <= SCAN3;
          Col_Sig <= ~SCAN3;
        end
        SCAN3: begin
          state   <= SCAN0;
          Col_Sig <= ~SCAN0;
        end
        default: begin
          state   <= SCAN0;
          Col_Sig <= ~SCAN0;
        end
      endcase
    end
  end

  // Rows settle long before the end of a slot, so the two-cycle
  // synchronizer lag after a column change is harmless.
  always_ff @(posedge clk) begin
    if (!rst) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      row_meta <= Row_Sig;
      row_sync <= row_meta;
    end
  end

  always_comb begin
    snap_nxt = snapshot;
    for (int r = 0; r < NUM_ROWS; r++) begin
      snap_nxt[{2'(r), col_sel}] = ~row_sync[r];
    end
  end

  // Every snapshot bit is rewritten once per frame, so no clear is needed
  // between frames; reset discards a partial one.
  always_ff @(posedge clk) begin
    if (!rst) begin
      snapshot    <= '0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= tick && (state == SCAN3);
      if (tick) snapshot <= snap_nxt;
    end
  end

  key_debounce #(
    .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
`ifdef KEY_REPEAT_EN
    ,
    .REPEAT_FRAMES   (REPEAT_FRAMES)
`endif
  ) u_debounce (
    .clk         (clk),
    .rst         (rst),
    .frame_valid (frame_valid),
    .snapshot    (snapshot),
    .key_code    (Key_Code),
    .key_valid   (Key_Valid),
    .key_down    (Key_Down)
  );

endmodule

// File: tb/tb_key_scan_module.sv
// tb/tb_key_scan_module.sv - self-checking bench for key_scan_module with a keypad model and event scoreboard
module tb_key_scan_module;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  Row_Sig;
  logic [3:0]  Col_Sig;
  logic [3:0]  Key_Code;
  logic        Key_Valid;
  logic        Key_Down;
  logic [15:0] pressed;

  int compared   = 0;
  int mismatched = 0;
  int consec     = 0;
  logic last_valid = 1'b0;

  logic [3:0] exp_q[$];
  logic [3:0] got_q[$];

  always #5 clk = ~clk;

  // Keypad: a pressed (r,c) pulls row r low while column c is driven low.
  always_comb begin
    Row_Sig = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !Col_Sig[c]) Row_Sig[r] = 1'b0;
      end
    end
  end

  key_scan_module #(
    .T1MS            (16'd9),
    .DEBOUNCE_FRAMES (4'd3),
    .REPEAT_FRAMES   (8'd5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .Row_Sig   (Row_Sig),
    .Col_Sig   (Col_Sig),
    .Key_Code  (Key_Code),
    .Key_Valid (Key_Valid),
    .Key_Down  (Key_Down)
  );

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (Key_Valid === 1'b1) begin
        got_q.push_back(Key_Code);
        if (last_valid) consec++;
      end
      last_valid = (Key_Valid === 1'b1);
    end
  endtask

  task automatic wait_pulse(input int bound, output int lat);
    int start;
    start = got_q.size();
    lat = -1;
    for (int i = 0; i < bound; i++) begin
      step(1);
      if (got_q.size() > start) begin
        lat = i + 1;
        break;
      end
    end
  endtask

  task automatic wait_release(input int bound, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      step(1);
      if (Key_Down === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    pressed = 16'h0000;
    step(3);
    compared++;
    if (Col_Sig !== 4'b1110) begin mismatched++; $display("FAIL reset_col: Col_Sig=%b, required 1110", Col_Sig); end
    compared++;
    if (Key_Valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid: Key_Valid=%b, required 0", Key_Valid); end
    compared++;
    if (Key_Down !== 1'b0) begin mismatched++; $display("FAIL reset_down: Key_Down=%b, required 0", Key_Down); end
    compared++;
    if (Key_Code !== 4'd0) begin mismatched++; $display("FAIL reset_code: Key_Code=%0d, required 0", Key_Code); end
    rst = 1'b1;
  endtask

  task automatic test_single_key;
    int lat;
    logic ok;
    logic [3:0] e, g;
    step(100);
    pressed = 16'h0040;
    exp_q.push_back(4'd6);
    wait_pulse(200, lat);
    compared++;
    if (lat < 80 || lat > 140) begin mismatched++; $display("FAIL single_latency: %0d cycles, required 80..140", lat); end
    step(40);
    compared++;
    if (Key_Down !== 1'b1) begin mismatched++; $display("FAIL single_down: Key_Down=%b, required 1", Key_Down); end
    compared++;
    if (Key_Code !== 4'd6) begin mismatched++; $display("FAIL single_hold_code: Key_Code=%0d, required 6", Key_Code); end
    pressed = 16'h0000;
    wait_release(200, ok);
    compared++;
    if (ok !== 1'b1) begin mismatched++; $display("FAIL single_release: Key_Down stuck at %b, required 0", Key_Down); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      compared++;
      if (got_q.size() == 0) begin mismatched++; $display("FAIL single_code: no pulse, required Key_Code=%0d", e); end
      else begin
        g = got_q.pop_front();
        if (g !== e) begin mismatched++; $display("FAIL single_code: Key_Code=%0d, required %0d", g, e); end
      end
    end
    compared++;
    if (got_q.size() != 0) begin mismatched++; $display("FAIL single_extra: %0d extra pulses, required 0", got_q.size()); got_q.delete(); end
  endtask

  task automatic test_bounce;
    int lat;
    logic ok;
    logic [3:0] e, g;
    pressed = 16'h0008;
    for (int i = 0; i < 5; i++) begin
      step(15);
      pressed = pressed ^ 16'h0008;
    end
    step(5);
    compared++;
    if (got_q.size() != 0) begin mismatched++; $display("FAIL bounce_quiet: %0d pulses during bounce, required 0", got_q.size()); got_q.delete(); end
    pressed = 16'h0008;
    exp_q.push_back(4'd3);
    wait_pulse(200, lat);
    compared++;
    if (lat < 0) begin mismatched++; $display("FAIL bounce_timeout: no pulse in 200 cycles, required one"); end
    step(40);
    pressed = 16'h0000;
    wait_release(200, ok);
    compared++;
    if (ok !== 1'b1) begin mismatched++; $display("FAIL bounce_release: Key_Down stuck at %b, required 0", Key_Down); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      compared++;
      if (got_q.size() == 0) begin mismatched++; $display("FAIL bounce_code: no pulse, required Key_Code=%0d", e); end
      else begin
        g = got_q.pop_front();
        if (g !== e) begin mismatched++; $display("FAIL bounce_code: Key_Code=%0d, required %0d", g, e); end
      end
    end
    compared++;
    if (got_q.size() != 0) begin mismatched++; $display("FAIL bounce_extra: %0d extra pulses, required 0", got_q.size()); got_q.delete(); end
  endtask

  task automatic test_multi_key;
    int lat;
    logic ok;
    logic [3:0] e, g;
    pressed = 16'h0021;
    step(250);
    compared++;
    if (got_q.size() != 0) begin mismatched++; $display("FAIL multi_no_pulse: %0d pulses, required 0", got_q.size()); got_q.delete(); end
    compared++;
    if (Key_Down !== 1'b1) begin mismatched++; $display("FAIL multi_down: Key_Down=%b, required 1", Key_Down); end
    pressed = 16'h0020;
    step(250);
    compared++;
    if (got_q.size() != 0) begin mismatched++; $display("FAIL multi_to_single: %0d pulses, required 0", got_q.size()); got_q.delete(); end
    compared++;
    if (Key_Down !== 1'b1) begin mismatched++; $display("FAIL multi_single_down: Key_Down=%b, required 1", Key_Down); end
    pressed = 16'h0000;
    wait_release(200, ok);
    compared++;
    if (ok !== 1'b1) begin mismatched++; $display("FAIL multi_release: Key_Down stuck at %b, required 0", Key_Down); end
    pressed = 16'h0020;
    exp_q.push_back(4'd5);
    wait_pulse(200, lat);
    compared++;
    if (lat < 0) begin mismatched++; $display("FAIL multi_timeout: no pulse in 200 cycles, required one"); end
    step(40);
    pressed = 16'h0000;
    wait_release(200, ok);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      compared++;
      if (got_q.size() == 0) begin mismatched++; $display("FAIL multi_code: no pulse, required Key_Code=%0d", e); end
      else begin
        g = got_q.pop_front();
        if (g !== e) begin mismatched++; $display("FAIL multi_code: Key_Code=%0d, required %0d", g, e); end
      end
    end
    compared++;
    if (got_q.size() != 0) begin mismatched++; $display("FAIL multi_extra: %0d extra pulses, required 0", got_q.size()); got_q.delete(); end
  endtask

  task automatic test_repress;
    int lat;
    logic ok;
    logic [3:0] e, g;
    for (int k = 0; k < 2; k++) begin
      pressed = 16'h0200;
      exp_q.push_back(4'd9);
      wait_pulse(200, lat);
      compared++;
      if (lat < 0) begin mismatched++; $display("FAIL repress_timeout: press %0d gave no pulse, required one", k); end
      step(40);
      pressed = 16'h0000;
      wait_release(200, ok);
      compared++;
      if (ok !== 1'b1) begin mismatched++; $display("FAIL repress_release: Key_Down stuck at %b, required 0", Key_Down); end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      compared++;
      if (got_q.size() == 0) begin mismatched++; $display("FAIL repress_code: no pulse, required Key_Code=%0d", e); end
      else begin
        g = got_q.pop_front();
        if (g !== e) begin mismatched++; $display("FAIL repress_code: Key_Code=%0d, required %0d", g, e); end
      end
    end
    compared++;
    if (got_q.size() != 0) begin mismatched++; $display("FAIL repress_extra: %0d extra pulses, required 0", got_q.size()); got_q.delete(); end
  endtask

  task automatic test_reset_mid;
    int lat;
    logic ok;
    logic [3:0] e, g;
    for (int i = 0; i < 50 && Col_Sig !== 4'b0111; i++) step(1);
    for (int i = 0; i < 50 && Col_Sig !== 4'b1110; i++) step(1);
    pressed = 16'h1000;
    step(85);
    for (int i = 0; i < 50 && Col_Sig !== 4'b1011; i++) step(1);
    compared++;
    if (got_q.size() != 0) begin mismatched++; $display("FAIL midreset_early: %0d pulses before reset, required 0", got_q.size()); got_q.delete(); end
    rst = 1'b0;
    step(1);
    compared++;
    if (Col_Sig !== 4'b1110) begin mismatched++; $display("FAIL midreset_col: Col_Sig=%b, required 1110", Col_Sig); end
    compared++;
    if (Key_Down !== 1'b0) begin mismatched++; $display("FAIL midreset_down: Key_Down=%b, required 0", Key_Down); end
    compared++;
    if (Key_Valid !== 1'b0) begin mismatched++; $display("FAIL midreset_valid0: Key_Valid=%b, required 0", Key_Valid); end
    rst = 1'b1;
    step(1);
    compared++;
    if (Key_Valid !== 1'b0) begin mismatched++; $display("FAIL midreset_valid1: Key_Valid=%b, required 0", Key_Valid); end
    exp_q.push_back(4'd12);
    wait_pulse(200, lat);
    compared++;
    if (lat < 117 || lat > 123) begin mismatched++; $display("FAIL midreset_latency: %0d cycles, required 117..123", lat); end
    step(40);
    pressed = 16'h0000;
    wait_release(200, ok);
    compared++;
    if (ok !== 1'b1) begin mismatched++; $display("FAIL midreset_release: Key_Down stuck at %b, required 0", Key_Down); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      compared++;
      if (got_q.size() == 0) begin mismatched++; $display("FAIL midreset_code: no pulse, required Key_Code=%0d", e); end
      else begin
        g = got_q.pop_front();
        if (g !== e) begin mismatched++; $display("FAIL midreset_code: Key_Code=%0d, required %0d", g, e); end
      end
    end
    compared++;
    if (got_q.size() != 0) begin mismatched++; $display("FAIL midreset_extra: %0d extra pulses, required 0", got_q.size()); got_q.delete(); end
  endtask

`ifdef KEY_REPEAT_EN
  task automatic test_repeat;
    int lat;
    logic ok;
    logic [3:0] e, g;
    pressed = 16'h8000;
    exp_q.push_back(4'd15);
    wait_pulse(200, lat);
    compared++;
    if (lat < 0) begin mismatched++; $display("FAIL repeat_first: no pulse in 200 cycles, required one"); end
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(4'd15);
      wait_pulse(260, lat);
      compared++;
      if (lat != 200) begin mismatched++; $display("FAIL repeat_period: interval %0d cycles, required 200", lat); end
    end
    pressed = 16'h0000;
    wait_release(200, ok);
    step(300);
    compared++;
    if (ok !== 1'b1) begin mismatched++; $display("FAIL repeat_release: Key_Down stuck at %b, required 0", Key_Down); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      compared++;
      if (got_q.size() == 0) begin mismatched++; $display("FAIL repeat_code: no pulse, required Key_Code=%0d", e); end
      else begin
        g = got_q.pop_front();
        if (g !== e) begin mismatched++; $display("FAIL repeat_code: Key_Code=%0d, required %0d", g, e); end
      end
    end
    compared++;
    if (got_q.size() != 0) begin mismatched++; $display("FAIL repeat_extra: %0d pulses after release, required 0", got_q.size()); got_q.delete(); end
  endtask
`endif

  task automatic test_back_to_back;
    compared++;
    if (consec != 0) begin mismatched++; $display("FAIL back_to_back: %0d consecutive Key_Valid cycles, required 0", consec); end
  endtask

  initial begin
    rst = 1'b0;
    pressed = 16'h0000;
    test_reset;
    test_single_key;
    test_bounce;
    test_multi_key;
    test_repress;
    test_reset_mid;
`ifdef KEY_REPEAT_EN
    test_repeat;
`endif
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
